// File: rtl/id_ex_stage_if.sv
// ============================================================================
// id_ex_stage_if : decode/forwarding/execute signal bundle for id_ex_stage
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface id_ex_stage_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH = 4
);
    logic                  id_valid_i;
    logic                  id_ready_o;
    logic [ADDR_WIDTH-1:0] id_rs1_addr_i;
    logic [ADDR_WIDTH-1:0] id_rs2_addr_i;
    logic [ADDR_WIDTH-1:0] id_rd_addr_i;
    logic [DATA_WIDTH-1:0] id_rs1_data_i;
    logic [DATA_WIDTH-1:0] id_rs2_data_i;
    logic [DATA_WIDTH-1:0] id_imm_i;
    logic                  id_alu_src_i;
    logic [CTRL_WIDTH-1:0] id_alu_ctrl_i;
    logic                  id_reg_write_i;
    logic                  id_mem_read_i;
    logic                  id_mem_write_i;
    logic                  id_branch_i;
    logic                  flush_i;
    logic                  mem_reg_write_i;
    logic [ADDR_WIDTH-1:0] mem_rd_addr_i;
    logic [DATA_WIDTH-1:0] mem_result_i;
    logic                  wb_reg_write_i;
    logic [ADDR_WIDTH-1:0] wb_rd_addr_i;
    logic [DATA_WIDTH-1:0] wb_result_i;
    logic                  ex_ready_i;
    logic                  ex_valid_o;
    logic [DATA_WIDTH-1:0] alu_op1_o;
    logic [DATA_WIDTH-1:0] alu_op2_o;
    logic [CTRL_WIDTH-1:0] alu_ctrl_o;
    logic [DATA_WIDTH-1:0] ex_store_data_o;
    logic [ADDR_WIDTH-1:0] ex_rd_addr_o;
    logic                  ex_reg_write_o;
    logic                  ex_mem_read_o;
    logic                  ex_mem_write_o;
    logic                  ex_branch_o;

    modport master (
        output id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_alu_src_i,
               id_alu_ctrl_i, id_reg_write_i, id_mem_read_i, id_mem_write_i,
               id_branch_i, flush_i, mem_reg_write_i, mem_rd_addr_i,
               mem_result_i, wb_reg_write_i, wb_rd_addr_i, wb_result_i,
               ex_ready_i,
        input  id_ready_o, ex_valid_o, alu_op1_o, alu_op2_o, alu_ctrl_o,
               ex_store_data_o, ex_rd_addr_o, ex_reg_write_o, ex_mem_read_o,
               ex_mem_write_o, ex_branch_o
    );

    modport slave (
        input  id_valid_i, id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i,
               id_rs1_data_i, id_rs2_data_i, id_imm_i, id_alu_src_i,
               id_alu_ctrl_i, id_reg_write_i, id_mem_read_i, id_mem_write_i,
               id_branch_i, flush_i, mem_reg_write_i, mem_rd_addr_i,
               mem_result_i, wb_reg_write_i, wb_rd_addr_i, wb_result_i,
               ex_ready_i,
        output id_ready_o, ex_valid_o, alu_op1_o, alu_op2_o, alu_ctrl_o,
               ex_store_data_o, ex_rd_addr_o, ex_reg_write_o, ex_mem_read_o,
               ex_mem_write_o, ex_branch_o
    );
endinterface

`default_nettype wire

// File: rtl/id_ex_stage.sv
// ============================================================================
// id_ex_stage : ID/EX pipeline register with operand forwarding and
//               load-use bubble insertion. Optional macro: ID_EX_FORWARD_EN
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CTRL_WIDTH = 4
) (
    input  wire logic     clk_i,
    input  wire logic     rst_i,
    id_ex_stage_if.slave  bus
);
    localparam logic [ADDR_WIDTH-1:0] c_X0 = '0;

    logic                  r_valid;
    logic                  r_reg_write;
    logic                  r_mem_read;
    logic                  r_mem_write;
    logic                  r_branch;
    logic                  r_alu_src;
    logic [CTRL_WIDTH-1:0] r_alu_ctrl;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic [ADDR_WIDTH-1:0] r_rs1_addr;
    logic [ADDR_WIDTH-1:0] r_rs2_addr;
    logic [DATA_WIDTH-1:0] r_rs1_data;
    logic [DATA_WIDTH-1:0] r_rs2_data;
    logic [DATA_WIDTH-1:0] r_imm;

    logic                  w_adv;
    logic                  w_hazard;
    logic [DATA_WIDTH-1:0] w_cap_rs1;
    logic [DATA_WIDTH-1:0] w_cap_rs2;
    logic [DATA_WIDTH-1:0] w_fwd_rs1;
    logic [DATA_WIDTH-1:0] w_fwd_rs2;

    assign w_adv = !r_valid || bus.ex_ready_i;

`ifdef ID_EX_FORWARD_EN
    always_comb begin
        w_hazard = r_valid && r_mem_read && (r_rd_addr != c_X0) &&
                   ((r_rd_addr == bus.id_rs1_addr_i) || (r_rd_addr == bus.id_rs2_addr_i));

        // WB writes the register file in the same cycle decode reads it.
        w_cap_rs1 = bus.id_rs1_data_i;
        w_cap_rs2 = bus.id_rs2_data_i;
        if (bus.wb_reg_write_i && (bus.wb_rd_addr_i != c_X0) &&
            (bus.wb_rd_addr_i == bus.id_rs1_addr_i))
            w_cap_rs1 = bus.wb_result_i;
        if (bus.wb_reg_write_i && (bus.wb_rd_addr_i != c_X0) &&
            (bus.wb_rd_addr_i == bus.id_rs2_addr_i))
            w_cap_rs2 = bus.wb_result_i;

        w_fwd_rs1 = r_rs1_data;
        if (bus.mem_reg_write_i && (bus.mem_rd_addr_i != c_X0) &&
            (bus.mem_rd_addr_i == r_rs1_addr))
            w_fwd_rs1 = bus.mem_result_i;
        else if (bus.wb_reg_write_i && (bus.wb_rd_addr_i != c_X0) &&
                 (bus.wb_rd_addr_i == r_rs1_addr))
            w_fwd_rs1 = bus.wb_result_i;

        w_fwd_rs2 = r_rs2_data;
        if (bus.mem_reg_write_i && (bus.mem_rd_addr_i != c_X0) &&
            (bus.mem_rd_addr_i == r_rs2_addr))
            w_fwd_rs2 = bus.mem_result_i;
        else if (bus.wb_reg_write_i && (bus.wb_rd_addr_i != c_X0) &&
                 (bus.wb_rd_addr_i == r_rs2_addr))
            w_fwd_rs2 = bus.wb_result_i;
    end
`else
    logic w_unused_fwd;

    assign w_hazard  = 1'b0;
    assign w_cap_rs1 = bus.id_rs1_data_i;
    assign w_cap_rs2 = bus.id_rs2_data_i;
    assign w_fwd_rs1 = r_rs1_data;
    assign w_fwd_rs2 = r_rs2_data;
    assign w_unused_fwd = ^{bus.mem_reg_write_i, bus.mem_rd_addr_i, bus.mem_result_i,
                            bus.wb_reg_write_i, bus.wb_rd_addr_i, bus.wb_result_i,
                            bus.id_rs1_addr_i, bus.id_rs2_addr_i, r_rs1_addr, r_rs2_addr};
`endif

    // Flush wins over everything; a bubble clears only valid and control bits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_branch    <= 1'b0;
            r_alu_src   <= 1'b0;
            r_alu_ctrl  <= '0;
            r_rd_addr   <= '0;
            r_rs1_addr  <= '0;
            r_rs2_addr  <= '0;
            r_rs1_data  <= '0;
            r_rs2_data  <= '0;
            r_imm       <= '0;
        end else if (bus.flush_i || (w_adv && (w_hazard || !bus.id_valid_i))) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_branch    <= 1'b0;
        end else if (w_adv) begin
            r_valid     <= 1'b1;
            r_reg_write <= bus.id_reg_write_i;
            r_mem_read  <= bus.id_mem_read_i;
            r_mem_write <= bus.id_mem_write_i;
            r_branch    <= bus.id_branch_i;
            r_alu_src   <= bus.id_alu_src_i;
            r_alu_ctrl  <= bus.id_alu_ctrl_i;
            r_rd_addr   <= bus.id_rd_addr_i;
            r_rs1_addr  <= bus.id_rs1_addr_i;
            r_rs2_addr  <= bus.id_rs2_addr_i;
            r_rs1_data  <= w_cap_rs1;
            r_rs2_data  <= w_cap_rs2;
            r_imm       <= bus.id_imm_i;
        end
    end

    assign bus.id_ready_o      = bus.flush_i || (w_adv && !w_hazard);
    assign bus.ex_valid_o      = r_valid;
    assign bus.alu_op1_o       = w_fwd_rs1;
    assign bus.alu_op2_o       = r_alu_src ? r_imm : w_fwd_rs2;
    assign bus.alu_ctrl_o      = r_alu_ctrl;
    assign bus.ex_store_data_o = w_fwd_rs2;
    assign bus.ex_rd_addr_o    = r_rd_addr;
    assign bus.ex_reg_write_o  = r_reg_write;
    assign bus.ex_mem_read_o   = r_mem_read;
    assign bus.ex_mem_write_o  = r_mem_write;
    assign bus.ex_branch_o     = r_branch;
endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// tb_id_ex_stage : directed self-checking bench for id_ex_stage
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    id_ex_stage_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CTRL_WIDTH(4)) bus ();

    id_ex_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CTRL_WIDTH(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_fwd();
        bus.mem_reg_write_i = 1'b0;
        bus.mem_rd_addr_i   = '0;
        bus.mem_result_i    = '0;
        bus.wb_reg_write_i  = 1'b0;
        bus.wb_rd_addr_i    = '0;
        bus.wb_result_i     = '0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic src, input logic [3:0] ctrl, input logic rw,
                         input logic mr, input logic mw, input logic br);
        bus.id_valid_i     = 1'b1;
        bus.id_rs1_addr_i  = rs1;
        bus.id_rs2_addr_i  = rs2;
        bus.id_rd_addr_i   = rd;
        bus.id_rs1_data_i  = d1;
        bus.id_rs2_data_i  = d2;
        bus.id_imm_i       = imm;
        bus.id_alu_src_i   = src;
        bus.id_alu_ctrl_i  = ctrl;
        bus.id_reg_write_i = rw;
        bus.id_mem_read_i  = mr;
        bus.id_mem_write_i = mw;
        bus.id_branch_i    = br;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        bus.ex_ready_i = 1'b0;
        issue(5'd1, 5'd2, 5'd7, 32'hAA, 32'hBB, 32'h0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        n_checks++;
        if (bus.ex_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre_valid: got %0h expected 1", bus.ex_valid_o);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.ex_valid_o, bus.ex_reg_write_o, bus.ex_rd_addr_o, bus.alu_ctrl_o} !== 11'd0) begin
            n_fail++; $display("FAIL rst_ctrl: got v=%0h rw=%0h rd=%0h ctrl=%0h expected all 0",
                               bus.ex_valid_o, bus.ex_reg_write_o, bus.ex_rd_addr_o, bus.alu_ctrl_o);
        end
        n_checks++;
        if ({bus.alu_op1_o, bus.alu_op2_o, bus.ex_store_data_o} !== 96'd0) begin
            n_fail++; $display("FAIL rst_data: got op1=%0h op2=%0h st=%0h expected 0",
                               bus.alu_op1_o, bus.alu_op2_o, bus.ex_store_data_o);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.id_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL rst_ready: got %0h expected 1", bus.id_ready_o);
        end
        bus.id_valid_i = 1'b0;
    endtask

    task automatic test_addi();
        bus.ex_ready_i = 1'b1;
        issue(5'd0, 5'd0, 5'd1, 32'h0, 32'hDEAD, 32'd5, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        bus.id_valid_i = 1'b0;
        n_checks++;
        if (bus.ex_valid_o !== 1'b1 || bus.ex_rd_addr_o !== 5'd1 || bus.ex_reg_write_o !== 1'b1) begin
            n_fail++; $display("FAIL addi_ctrl: got v=%0h rd=%0h rw=%0h expected v=1 rd=1 rw=1",
                               bus.ex_valid_o, bus.ex_rd_addr_o, bus.ex_reg_write_o);
        end
        n_checks++;
        if (bus.alu_op1_o !== 32'd0 || bus.alu_op2_o !== 32'd5 || bus.alu_ctrl_o !== 4'b0000) begin
            n_fail++; $display("FAIL addi_ops: got op1=%0h op2=%0h ctrl=%0h expected 0 5 0",
                               bus.alu_op1_o, bus.alu_op2_o, bus.alu_ctrl_o);
        end
        n_checks++;
        if (bus.ex_store_data_o !== 32'hDEAD) begin
            n_fail++; $display("FAIL addi_store: got %0h expected dead", bus.ex_store_data_o);
        end
    endtask

    task automatic test_forward();
        logic [31:0] exp1;
        logic [31:0] exp2;
        // WB writes x2 while ADD x3=x1+x2 is in decode
        issue(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.wb_reg_write_i = 1'b1; bus.wb_rd_addr_i = 5'd2; bus.wb_result_i = 32'd4;
        tick();
        bus.id_valid_i = 1'b0;
        bus.mem_reg_write_i = 1'b1; bus.mem_rd_addr_i = 5'd1; bus.mem_result_i = 32'd7;
        bus.wb_reg_write_i  = 1'b1; bus.wb_rd_addr_i  = 5'd1; bus.wb_result_i  = 32'd9;
        #1;
`ifdef ID_EX_FORWARD_EN
        exp1 = 32'd7; exp2 = 32'd4;
`else
        exp1 = 32'h11; exp2 = 32'h22;
`endif
        n_checks++;
        if (bus.alu_op1_o !== exp1) begin
            n_fail++; $display("FAIL fwd_mem_op1: got %0h expected %0h", bus.alu_op1_o, exp1);
        end
        n_checks++;
        if (bus.alu_op2_o !== exp2 || bus.ex_store_data_o !== exp2) begin
            n_fail++; $display("FAIL fwd_op2: got op2=%0h st=%0h expected %0h",
                               bus.alu_op2_o, bus.ex_store_data_o, exp2);
        end
        bus.mem_reg_write_i = 1'b0;
        #1;
`ifdef ID_EX_FORWARD_EN
        exp1 = 32'd9;
`else
        exp1 = 32'h11;
`endif
        n_checks++;
        if (bus.alu_op1_o !== exp1) begin
            n_fail++; $display("FAIL fwd_wb_op1: got %0h expected %0h", bus.alu_op1_o, exp1);
        end
        // x0 matches must never forward
        idle_fwd();
        issue(5'd0, 5'd0, 5'd4, 32'h50, 32'h60, 32'h0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.wb_reg_write_i = 1'b1; bus.wb_rd_addr_i = 5'd0; bus.wb_result_i = 32'h99;
        tick();
        bus.id_valid_i = 1'b0;
        bus.mem_reg_write_i = 1'b1; bus.mem_rd_addr_i = 5'd0; bus.mem_result_i = 32'd7;
        #1;
        n_checks++;
        if (bus.alu_op1_o !== 32'h50 || bus.alu_op2_o !== 32'h60) begin
            n_fail++; $display("FAIL fwd_x0: got op1=%0h op2=%0h expected 50 60",
                               bus.alu_op1_o, bus.alu_op2_o);
        end
        idle_fwd();
    endtask

    task automatic test_load_use();
        bus.ex_ready_i = 1'b1;
        issue(5'd2, 5'd0, 5'd5, 32'h0, 32'h0, 32'd8, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        issue(5'd5, 5'd5, 5'd6, 32'hBAD1, 32'hBAD2, 32'h0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
`ifdef ID_EX_FORWARD_EN
        n_checks++;
        if (bus.id_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL lu_stall_ready: got %0h expected 0", bus.id_ready_o);
        end
        tick();
        n_checks++;
        if (bus.ex_valid_o !== 1'b0 || bus.ex_mem_read_o !== 1'b0 || bus.ex_reg_write_o !== 1'b0) begin
            n_fail++; $display("FAIL lu_bubble: got v=%0h mr=%0h rw=%0h expected 0 0 0",
                               bus.ex_valid_o, bus.ex_mem_read_o, bus.ex_reg_write_o);
        end
        n_checks++;
        if (bus.id_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL lu_bubble_ready: got %0h expected 1", bus.id_ready_o);
        end
        tick();
        bus.id_valid_i = 1'b0;
        bus.mem_reg_write_i = 1'b1; bus.mem_rd_addr_i = 5'd5; bus.mem_result_i = 32'h1234;
        #1;
        n_checks++;
        if (bus.ex_valid_o !== 1'b1 || bus.ex_rd_addr_o !== 5'd6 ||
            bus.alu_op1_o !== 32'h1234 || bus.alu_op2_o !== 32'h1234) begin
            n_fail++; $display("FAIL lu_fwd: got v=%0h rd=%0h op1=%0h op2=%0h expected 1 6 1234 1234",
                               bus.ex_valid_o, bus.ex_rd_addr_o, bus.alu_op1_o, bus.alu_op2_o);
        end
`else
        n_checks++;
        if (bus.id_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL lu_noh_ready: got %0h expected 1", bus.id_ready_o);
        end
        tick();
        bus.id_valid_i = 1'b0;
        bus.mem_reg_write_i = 1'b1; bus.mem_rd_addr_i = 5'd5; bus.mem_result_i = 32'h1234;
        #1;
        n_checks++;
        if (bus.ex_valid_o !== 1'b1 || bus.ex_rd_addr_o !== 5'd6 ||
            bus.alu_op1_o !== 32'hBAD1 || bus.alu_op2_o !== 32'hBAD2) begin
            n_fail++; $display("FAIL lu_nofwd: got v=%0h rd=%0h op1=%0h op2=%0h expected 1 6 bad1 bad2",
                               bus.ex_valid_o, bus.ex_rd_addr_o, bus.alu_op1_o, bus.alu_op2_o);
        end
`endif
        idle_fwd();
    endtask

    task automatic test_stall();
        bus.ex_ready_i = 1'b1;
        issue(5'd1, 5'd2, 5'd9, 32'h100, 32'h200, 32'h0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        issue(5'd3, 5'd4, 5'd10, 32'h300, 32'h400, 32'h0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.ex_ready_i = 1'b0;
        #1;
        n_checks++;
        if (bus.id_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL stall_ready: got %0h expected 0", bus.id_ready_o);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (bus.ex_valid_o !== 1'b1 || bus.ex_rd_addr_o !== 5'd9 || bus.alu_op1_o !== 32'h100 ||
                bus.alu_ctrl_o !== 4'd1 || bus.ex_mem_write_o !== 1'b1 || bus.ex_branch_o !== 1'b1 ||
                bus.id_ready_o !== 1'b0) begin
                n_fail++; $display("FAIL stall_hold%0d: got v=%0h rd=%0h op1=%0h ctrl=%0h mw=%0h br=%0h rdy=%0h expected 1 9 100 1 1 1 0",
                                   i, bus.ex_valid_o, bus.ex_rd_addr_o, bus.alu_op1_o, bus.alu_ctrl_o,
                                   bus.ex_mem_write_o, bus.ex_branch_o, bus.id_ready_o);
            end
        end
        bus.ex_ready_i = 1'b1;
        #1;
        n_checks++;
        if (bus.id_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL stall_release_ready: got %0h expected 1", bus.id_ready_o);
        end
        tick();
        bus.id_valid_i = 1'b0;
        n_checks++;
        if (bus.ex_valid_o !== 1'b1 || bus.ex_rd_addr_o !== 5'd10 ||
            bus.alu_op1_o !== 32'h300 || bus.alu_ctrl_o !== 4'd2) begin
            n_fail++; $display("FAIL stall_next: got v=%0h rd=%0h op1=%0h ctrl=%0h expected 1 a 300 2",
                               bus.ex_valid_o, bus.ex_rd_addr_o, bus.alu_op1_o, bus.alu_ctrl_o);
        end
    endtask

    task automatic test_flush();
        bus.ex_ready_i = 1'b1;
        issue(5'd1, 5'd2, 5'd12, 32'h500, 32'h600, 32'h0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b1, 1'b1);
        tick();
        issue(5'd7, 5'd8, 5'd11, 32'h700, 32'h800, 32'h0, 1'b0, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0);
        bus.ex_ready_i = 1'b0;
        bus.flush_i    = 1'b1;
        #1;
        n_checks++;
        if (bus.id_ready_o !== 1'b1) begin
            n_fail++; $display("FAIL flush_ready: got %0h expected 1", bus.id_ready_o);
        end
        tick();
        bus.flush_i    = 1'b0;
        bus.id_valid_i = 1'b0;
        n_checks++;
        if ({bus.ex_valid_o, bus.ex_reg_write_o, bus.ex_mem_read_o, bus.ex_mem_write_o, bus.ex_branch_o} !== 5'd0) begin
            n_fail++; $display("FAIL flush_ctrl: got v=%0h rw=%0h mr=%0h mw=%0h br=%0h expected all 0",
                               bus.ex_valid_o, bus.ex_reg_write_o, bus.ex_mem_read_o,
                               bus.ex_mem_write_o, bus.ex_branch_o);
        end
        n_checks++;
        if (bus.ex_rd_addr_o !== 5'd12 || bus.alu_ctrl_o !== 4'd5) begin
            n_fail++; $display("FAIL flush_drop: got rd=%0h ctrl=%0h expected c 5",
                               bus.ex_rd_addr_o, bus.alu_ctrl_o);
        end
        tick();
        n_checks++;
        if (bus.ex_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_after: got %0h expected 0", bus.ex_valid_o);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        bus.flush_i    = 1'b0;
        bus.ex_ready_i = 1'b1;
        issue('0, '0, '0, '0, '0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        bus.id_valid_i = 1'b0;
        idle_fwd();
        test_reset();
        test_addi();
        test_forward();
        test_load_use();
        test_stall();
        test_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
